// File: rtl/fft_frame_serializer_pkg.sv
// rtl/fft_frame_serializer_pkg.sv - shared FFT types and bit-reversal helper
package fft_frame_serializer_pkg;

  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_product_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_t;

  // Reverses the low `width` bits of v; bits above width come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
    logic [31:0] res;
    res = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < width) res[b] = v[width-1-b];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_frame_serializer_if.sv
// rtl/fft_frame_serializer_if.sv - frame input and sample stream bundle
interface fft_frame_serializer_if
  import fft_frame_serializer_pkg::*;
#(
  parameter int N = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N*64-1:0]  frame_in;
  logic             frame_valid;
  logic             frame_mode;
  complex_product_t sample_out;
  logic             sample_valid;
  logic             sample_ready;
  logic             sample_mode;
  logic [IW-1:0]    sample_index;
  logic             sample_last;
  logic             overflow;

  modport master (
    input  frame_in, frame_valid, frame_mode, sample_ready,
    output sample_out, sample_valid, sample_mode, sample_index, sample_last, overflow
  );

  modport slave (
    output frame_in, frame_valid, frame_mode, sample_ready,
    input  sample_out, sample_valid, sample_mode, sample_index, sample_last, overflow
  );

endinterface

// File: rtl/fft_frame_serializer_slot.sv
// rtl/fft_frame_serializer_slot.sv - one N-element frame bank with full flag, mode and indexed read
module fft_frame_serializer_slot
  import fft_frame_serializer_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [N*64-1:0]  frame,
  input  logic             mode_in,
  input  logic [IW-1:0]    rd_idx,
  output logic             full,
  output logic             mode,
  output complex_product_t rd_data
);

  complex_product_t data [N];

  // Payload is not reset: it is only observable while full is set.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < N; j++) data[j] <= frame[j*64 +: 64];
    end
  end

  // A load wins over a clear so a slot can be drained and refilled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      mode <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      mode <= mode_in;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  assign rd_data = data[rd_idx];

endmodule

// File: rtl/fft_frame_serializer.sv
// rtl/fft_frame_serializer.sv - ping-pong buffer turning a parallel FFT frame into a valid/ready sample stream
module fft_frame_serializer
  import fft_frame_serializer_pkg::*;
#(
  parameter int N           = 8,
  parameter bit BIT_REVERSE = 1'b0
) (
  input logic clk,
  input logic reset,
  fft_frame_serializer_if.master bus
);

  localparam int            IW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] K_LAST = IW'(N - 1);

  ser_state_t       state, state_next;
  logic             wr_sel, rd_sel;
  logic [IW-1:0]    k, rd_idx;
  logic             overflow_q;
  logic [1:0]       slot_full, slot_mode, slot_load, slot_clear;
  complex_product_t slot_data [2];
  logic             sample_valid, hs, last_hs, wr_free, capture, drop;

  assign sample_valid = (state == ST_STREAM);
  assign hs           = sample_valid & bus.sample_ready;
  assign last_hs      = hs & (k == K_LAST);
  // The slot finishing its last handshake this cycle is free for an incoming frame.
  assign wr_free      = ~slot_full[wr_sel] | (last_hs & (rd_sel == wr_sel));
  assign capture      = bus.frame_valid & wr_free & ~reset;
  assign drop         = bus.frame_valid & ~wr_free & ~reset;
  assign rd_idx       = BIT_REVERSE ? IW'(bitrev(32'(k), IW)) : k;

  always_comb begin
    slot_load          = '0;
    slot_clear         = '0;
    slot_load[wr_sel]  = capture;
    slot_clear[rd_sel] = last_hs;
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    fft_frame_serializer_slot #(.N(N), .IW(IW)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (slot_load[s]),
      .clear   (slot_clear[s]),
      .frame   (bus.frame_in),
      .mode_in (bus.frame_mode),
      .rd_idx  (rd_idx),
      .full    (slot_full[s]),
      .mode    (slot_mode[s]),
      .rd_data (slot_data[s])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (capture) state_next = ST_STREAM;
      ST_STREAM: if (last_hs && !(slot_full[~rd_sel] || capture)) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      k          <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (capture) wr_sel <= ~wr_sel;
      if (last_hs) begin
        rd_sel <= ~rd_sel;
        k      <= '0;
      end else if (hs) begin
        k <= k + IW'(1);
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.sample_valid = sample_valid;
  assign bus.sample_out   = sample_valid ? slot_data[rd_sel] : '0;
  assign bus.sample_mode  = sample_valid & slot_mode[rd_sel];
  assign bus.sample_index = k;
  assign bus.sample_last  = sample_valid & (k == K_LAST);
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb/tb_fft_frame_serializer.sv - natural and bit-reversed serializers against a frame-queue model
module tb_fft_frame_serializer;
  import fft_frame_serializer_pkg::*;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*64-1:0] frame_in = '0;
  logic           frame_valid = 1'b0;
  logic           frame_mode = 1'b0;
  logic           sample_ready = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fft_frame_serializer_if #(.N(N)) bus0 ();
  fft_frame_serializer_if #(.N(N)) bus1 ();

  assign bus0.frame_in = frame_in;
  assign bus0.frame_valid = frame_valid;
  assign bus0.frame_mode = frame_mode;
  assign bus0.sample_ready = sample_ready;
  assign bus1.frame_in = frame_in;
  assign bus1.frame_valid = frame_valid;
  assign bus1.frame_mode = frame_mode;
  assign bus1.sample_ready = sample_ready;

  fft_frame_serializer #(.N(N), .BIT_REVERSE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fft_frame_serializer #(.N(N), .BIT_REVERSE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Model: up to two stored frames in arrival order, plus the drain position of the head.
  logic [N*64-1:0] fq [$];
  logic            mq [$];
  int              pos = 0;
  logic            ovf_m = 1'b0;

  function automatic logic [N*64-1:0] mkframe(input int base_r, input int mul_i);
    logic [N*64-1:0] f;
    for (int j = 0; j < N; j++) f[j*64 +: 64] = {32'(base_r + j), 32'(-(mul_i * j))};
    return f;
  endfunction

  function automatic int brev3(input int p);
    return ((p % 2) * 4) + (((p / 2) % 2) * 2) + ((p / 4) % 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endtask

  task automatic cmp(input int b, input logic v, input logic [63:0] o, input logic [2:0] idx,
                     input logic l, input logic m, input logic ov);
    logic [N*64-1:0] fr;
    logic            ev;
    logic [63:0]     eo;
    int              e;
    ev = (fq.size() > 0);
    eo = '0;
    if (ev) begin
      fr = fq[0];
      e  = (b == 1) ? brev3(pos) : pos;
      eo = fr[e*64 +: 64];
    end
    chk($sformatf("d%0d valid", b), 64'(v), 64'(ev));
    chk($sformatf("d%0d out", b), o, eo);
    chk($sformatf("d%0d index", b), 64'(idx), 64'(pos));
    chk($sformatf("d%0d last", b), 64'(l), 64'(ev && pos == N - 1));
    chk($sformatf("d%0d overflow", b), 64'(ov), 64'(ovf_m));
    if (ev) chk($sformatf("d%0d mode", b), 64'(m), 64'(mq[0]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp(0, bus0.sample_valid, bus0.sample_out, bus0.sample_index, bus0.sample_last, bus0.sample_mode, bus0.overflow);
      cmp(1, bus1.sample_valid, bus1.sample_out, bus1.sample_index, bus1.sample_last, bus1.sample_mode, bus1.overflow);
      @(posedge clk);
      if (reset) begin
        fq.delete();
        mq.delete();
        pos   = 0;
        ovf_m = 1'b0;
      end else begin
        if (fq.size() > 0 && sample_ready) begin
          pos++;
          if (pos == N) begin
            void'(fq.pop_front());
            void'(mq.pop_front());
            pos = 0;
          end
        end
        if (frame_valid) begin
          if (fq.size() < 2) begin
            fq.push_back(frame_in);
            mq.push_back(frame_mode);
          end else begin
            ovf_m = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [N*64-1:0] f, input logic m);
    frame_in    = f;
    frame_mode  = m;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  logic [N*64-1:0] fa, fb, fc;
  int rev_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  initial begin
    fa = mkframe(0, 1);
    fb = mkframe(100, 3);
    fc = mkframe(200, 7);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Single frame: natural and bit-reversed order, cycles t+1..t+8.
    sample_ready = 1'b1;
    strobe(fa, 1'b0);
    for (int s = 0; s < N; s++) begin
      @(negedge clk);
      chk("t1 nat sample", bus0.sample_out, {32'(s), 32'(-s)});
      chk("t1 rev r", 64'(bus1.sample_out.r), 64'(rev_exp[s]));
      chk("t1 last", 64'(bus0.sample_last), 64'(s == N - 1));
    end
    @(negedge clk);
    chk("t1 valid after frame", 64'(bus0.sample_valid), 64'(0));

    // Stall pattern 1,0,0,1 across a frame.
    tick();
    strobe(fb, 1'b1);
    for (int c = 0; c < 24; c++) begin
      sample_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    sample_ready = 1'b1;
    repeat (10) tick();

    // A at t, B at t+3: B sample 0 at t+9, no gap.
    strobe(fa, 1'b0);
    tick();
    tick();
    strobe(fb, 1'b1);
    repeat (5) @(negedge clk);
    chk("t4 A last index", 64'(bus0.sample_index), 64'(7));
    chk("t4 A mode", 64'(bus0.sample_mode), 64'(0));
    @(negedge clk);
    chk("t4 B valid", 64'(bus0.sample_valid), 64'(1));
    chk("t4 B sample0", bus0.sample_out, {32'(100), 32'(0)});
    chk("t4 B mode", 64'(bus0.sample_mode), 64'(1));
    repeat (10) tick();
    chk("t4 overflow", 64'(bus0.overflow), 64'(0));

    // Three frames with ready low: third dropped, overflow sticky.
    sample_ready = 1'b0;
    strobe(fa, 1'b0);
    strobe(fb, 1'b1);
    strobe(fc, 1'b0);
    @(negedge clk);
    chk("t5 overflow set", 64'(bus0.overflow), 64'(1));
    repeat (3) tick();
    sample_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    chk("t5 overflow sticky", 64'(bus1.overflow), 64'(1));
    chk("t5 drained", 64'(bus1.sample_valid), 64'(0));

    // Reset at sample 4, with a strobe during reset that must be ignored.
    tick();
    strobe(fa, 1'b0);
    repeat (4) tick();
    @(negedge clk);
    chk("t6 at sample4", 64'(bus0.sample_index), 64'(4));
    reset       = 1'b1;
    frame_in    = fc;
    frame_valid = 1'b1;
    tick();
    reset       = 1'b0;
    frame_valid = 1'b0;
    @(negedge clk);
    chk("t6 valid after reset", 64'(bus0.sample_valid), 64'(0));
    chk("t6 overflow after reset", 64'(bus0.overflow), 64'(0));
    chk("t6 out after reset", bus1.sample_out, 64'(0));
    strobe(fb, 1'b1);
    @(negedge clk);
    chk("t6 restart index", 64'(bus0.sample_index), 64'(0));
    chk("t6 restart sample", bus0.sample_out, {32'(100), 32'(0)});
    repeat (10) tick();

    // Strobe on the last-sample handshake while the other slot is full.
    strobe(fa, 1'b0);
    strobe(fb, 1'b1);
    repeat (6) tick();
    strobe(fc, 1'b0);
    repeat (9) @(negedge clk);
    chk("t7 C sample0", bus0.sample_out, {32'(200), 32'(0)});
    chk("t7 C mode", 64'(bus0.sample_mode), 64'(0));
    chk("t7 no overflow", 64'(bus0.overflow), 64'(0));
    repeat (12) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fft_frame_serializer.md
# fft_frame_serializer

Converts the parallel N-point frame produced by `fft_N_rad2` (flattened `fft_out` bus, `out_valid` pulse, `output_mode` stream tag) back into a one-sample-per-cycle complex stream with valid/ready handshake. It sits between the FFT and the per-subcarrier back end (demapper / equalizer). It has two frame slots (ping-pong), so one frame can be captured while the other drains. It can optionally undo bit-reversed bin ordering.

## Interface
- `N`, 8: FFT size. Power of two, ≥ 2.
- `BIT_REVERSE`, 0: 1 means sample k is emitted from input element bitrev(k). 0 means natural order.
- `clk` in, 1: clock.
- `reset` in, 1: synchronous, active-high reset.
- `frame_in` in, N*64: flattened FFT frame. Element j is `frame_in[j*64 +: 64]`, with bits [63:32] = r and [31:0] = i (`complex_product_t` packing).
- `frame_valid` in, 1: single-cycle frame strobe. No backpressure is available upstream.
- `frame_mode` in, 1: stream tag latched with the frame (0 = antenna 0, 1 = antenna 1).
- `sample_out` out, 64: `complex_product_t` sample.
- `sample_valid` out, 1: `sample_out` is valid.
- `sample_ready` in, 1: downstream accepts `sample_out`.
- `sample_mode` out, 1: tag of the frame currently draining.
- `sample_index` out, $clog2(N): bin index k (0..N-1).
- `sample_last` out, 1: high with k = N-1.
- `overflow` out, 1: sticky flag, set when a frame is dropped.

## Operation
- State is two slots, each holding {data[N], mode, full}, plus `wr_sel` (next slot to fill), `rd_sel` (slot draining), and an index counter `k`.
- FSM states:
  - IDLE: no slot full. Moves to STREAM on the edge that captures a frame.
  - STREAM: slot `rd_sel` is full. On a handshake (`sample_valid & sample_ready`), k increments.
  - On a handshake with k = N-1:
    - slot `rd_sel` is cleared, `rd_sel` toggles, and k returns to 0;
    - the FSM stays in STREAM if the other slot is full (or is being filled this cycle), otherwise it goes to IDLE.
- Capture:
  - `frame_valid` with slot `wr_sel` not full: store the frame and `frame_mode` into that slot, set full, toggle `wr_sel`.
  - A slot freed by a last-sample handshake in the same cycle counts as free. The frame is accepted, with no loss.
- Overflow: `frame_valid` while both slots are full and no slot is freed that cycle drops the frame. Stored data is untouched and `overflow` goes to 1. Only reset clears `overflow`.
- Output is a combinational mux from slot `rd_sel`:
  - `sample_out` = element (BIT_REVERSE ? bitrev(k) : k);
  - `sample_mode` = slot mode;
  - `sample_index` = k;
  - `sample_last` = (k == N-1) & `sample_valid`.
- `sample_valid` = (state == STREAM). Data is passed through unmodified, with no scaling or sign change.
- `frame_valid` in any cycle with `reset` high is ignored.

## Timing
- Reset values:
  - state IDLE, both slots empty, `wr_sel` = `rd_sel` = 0, k = 0;
  - `sample_valid` 0, `sample_index` 0, `sample_last` 0, `sample_mode` 0, `overflow` 0;
  - `sample_out` 0 (the mux output is forced to 0 when not valid).
- Latency:
  - A frame strobed in cycle t (captured at the rising edge ending t) presents sample 0 in cycle t+1 if the block was idle.
  - With `sample_ready` held high, samples 0..N-1 appear in cycles t+1..t+N.
  - Sustained throughput is 1 sample/cycle. Back-to-back frames drain with no bubble.
- Valid/ready rules:
  - While `sample_valid` is high and `sample_ready` is low, `sample_out`, `sample_index`, `sample_mode` and `sample_last` hold stable.
  - `sample_valid` never drops without a handshake except on reset.
- Reset mid-frame: on the reset edge, all slots and the partially drained frame are discarded. The next cycle matches the reset values.

## Structure
- `complex_product_t` and a `bitrev` function (width $clog2(N)) belong in the shared FFT package. No new typedefs are needed.
- Natural sub-module: `fft_frame_slot`, one N×64 register bank with load enable, full flag, mode, and an indexed read port. Instantiate it twice.
- The top level holds the FSM, pointers, the index counter, and the overflow logic.

## Test plan
- Single frame, N=8, BIT_REVERSE=0, element j = {r=j, i=-j}, mode 0, ready held 1 -> 8 samples in cycles t+1..t+8 with r = 0..7, i = 0..-7, last only on index 7, then `sample_valid` = 0.
- BIT_REVERSE=1, same frame -> r order 0,4,2,6,1,5,3,7.
- Ready toggling 1,0,0,1,... during a frame -> outputs stable while stalled, and no sample is skipped or duplicated.
- Frames A (mode 0) at t and B (mode 1) at t+3, ready held 1 -> A drains fully, then B's sample 0 follows at t+9 with `sample_mode` = 1, no gap, and `overflow` = 0.
- Ready held 0, three frames strobed -> first two are retained and the third is dropped. `overflow` = 1 and stays 1 after the frames drain.
- Reset asserted at A's sample 4 -> the next cycle shows `sample_valid` 0 and `overflow` 0. A new frame afterward starts at index 0.
- Frame strobed in the same cycle as the last-sample handshake of the previous frame, with the other slot full -> accepted, no overflow.
